// File: rtl/matmul_pkg.sv
// Shared types and helpers for the 2x2 matrix multiplier result path.
// Holds the serializer states, the result-matrix view and the stored frame layout.
package matmul_pkg;

    localparam int ELEM_W = 5;
    localparam int FRAME_BYTES = 6;
    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_ELEM,
        S_CSUM
    } ser_state_e;

    typedef struct packed {
        logic signed [ELEM_W-1:0] c00;
        logic signed [ELEM_W-1:0] c01;
        logic signed [ELEM_W-1:0] c10;
        logic signed [ELEM_W-1:0] c11;
    } cmat_t;

    // elem[3] holds c00, elem[0] holds c11
    typedef struct packed {
        logic [3:0]      seq;
        logic [3:0][7:0] elem;
        logic [7:0]      csum;
    } frame_t;

    function automatic logic [7:0] sext8(input logic [ELEM_W-1:0] v);
        return {{(8-ELEM_W){v[ELEM_W-1]}}, v};
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Frame FIFO for captured result matrices.
// A push on a full FIFO is legal when a pop frees the head slot on the same edge.
module result_fifo
    import matmul_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  frame_t                   din,
    input  logic                     pop,
    output frame_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    frame_t      mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) wr_d = wr_q + (AW+1)'(1);
        if (pop)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= din;
    end

    assign dout  = mem_q[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count = wr_q - rd_q;

endmodule

// File: rtl/matmul_result_streamer.sv
// Captures result matrices into a frame FIFO and streams them as 6-byte
// packets: header, four sign-extended elements, XOR checksum.
module matmul_result_streamer
    import matmul_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [19:0] c_in,
    input  logic        c_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    input  logic        clr_ovf,
    output logic        busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    ser_state_e      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      seq_q, seq_d;
    logic            ovf_q, ovf_d;

    cmat_t           cm;
    frame_t          wr_frame, head;
    logic [7:0]      hdr_b;
    logic            push, pop, full, empty, req, hs, more;
    logic [CW-1:0]   count;

    assign cm = c_in;

    always_comb begin
        hdr_b         = {HDR_NIBBLE, seq_q};
        wr_frame.seq  = seq_q;
        wr_frame.elem = {sext8(cm.c00), sext8(cm.c01),
                         sext8(cm.c10), sext8(cm.c11)};
        wr_frame.csum = hdr_b ^ wr_frame.elem[3] ^ wr_frame.elem[2] ^
                        wr_frame.elem[1] ^ wr_frame.elem[0];
    end

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wr_frame),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign hs   = out_valid && out_ready;
    assign pop  = (state_q == S_CSUM) && hs;
    assign req  = ena && c_valid;
    assign push = req && (!full || pop);
    // another frame follows if one is queued behind the head or lands now
    assign more = (count > CW'(1)) || push;

    always_comb begin
        seq_d = push ? seq_q + 4'd1 : seq_q;
        ovf_d = ovf_q;
        if (req && !push) ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: if (!empty || push) state_d = S_HDR;
            S_HDR: begin
                if (hs) begin
                    state_d = S_ELEM;
                    idx_d   = '0;
                end
            end
            S_ELEM: begin
                if (hs) begin
                    if (idx_q == 2'd3) state_d = S_CSUM;
                    else               idx_d   = idx_q + 2'd1;
                end
            end
            S_CSUM: if (hs) state_d = more ? S_HDR : S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        unique case (state_q)
            S_IDLE: ;
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = {HDR_NIBBLE, head.seq};
            end
            S_ELEM: begin
                out_valid = 1'b1;
                out_data  = head.elem[2'd3 - idx_q];
            end
            S_CSUM: begin
                out_valid = 1'b1;
                out_data  = head.csum;
            end
        endcase
    end

    assign overflow = ovf_q;
    assign busy     = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Bench for matmul_result_streamer: directed scenarios plus random traffic
// compared against a frame-queue model of the byte stream.
module tb_matmul_result_streamer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b0;
    logic [19:0] c_in = '0;
    logic        c_valid = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        clr_ovf = 1'b0;
    logic        busy;

    matmul_result_streamer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .c_in      (c_in),
        .c_valid   (c_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] mq[$];
    int          pos;
    logic [3:0]  mseq;
    logic        movf;
    logic [7:0]  sent[$];

    localparam logic [19:0] C_EX = {5'd3, 5'h1F, 5'd0, 5'd8};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] make_frame(input logic [3:0] s,
                                               input logic [19:0] c);
        logic [7:0] b[6];
        int v;
        b[0] = {4'hA, s};
        for (int k = 0; k < 4; k++) begin
            v = $signed(c[19-5*k -: 5]);
            b[k+1] = v[7:0];
        end
        b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
        return {b[0], b[1], b[2], b[3], b[4], b[5]};
    endfunction

    task automatic check_outputs();
        logic [47:0] f;
        check("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            f = mq[0];
            check("out_data", out_data, f[47-8*pos -: 8]);
        end
        check("overflow", overflow, movf);
        check("busy", busy, mq.size() > 0);
    endtask

    task automatic step(input logic e, input logic cv, input logic [19:0] c,
                        input logic rdy, input logic clr);
        logic hs, pop, acc;
        ena = e; c_valid = cv; c_in = c; out_ready = rdy; clr_ovf = clr;
        if (out_valid && rdy) sent.push_back(out_data);
        @(posedge clk);
        hs  = (mq.size() > 0) && rdy;
        pop = hs && (pos == 5);
        acc = e && cv && ((mq.size() < DEPTH) || pop);
        if (hs) pos++;
        if (pop) begin
            void'(mq.pop_front());
            pos = 0;
        end
        if (acc) begin
            mq.push_back(make_frame(mseq, c));
            mseq++;
        end
        if (e && cv && !acc) movf = 1'b1;
        else if (clr)        movf = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena = 1'b0; c_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        mq.delete(); pos = 0; mseq = '0; movf = 1'b0;
        sent.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (mq.size() != 0 && n < budget) begin
            step(1'b1, 1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check("drain_done", mq.size(), 0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_b[6];
        exp_b = '{8'hA0, 8'h03, 8'hFF, 8'h00, 8'h08, 8'h54};
        #3;
        do_reset();

        // single frame, consumer always ready
        step(1, 1, C_EX, 1, 0);
        check("lat_valid", out_valid, 1);
        for (int i = 0; i < 6; i++) step(1, 0, '0, 1, 0);
        check("single_len", sent.size(), 6);
        for (int i = 0; i < 6 && i < sent.size(); i++)
            check($sformatf("single_b%0d", i), sent[i], exp_b[i]);
        check("single_idle", out_valid, 0);
        check("single_busy", busy, 0);

        // same frame under back-pressure pattern 1,0,0,1,...
        do_reset();
        step(1, 1, C_EX, 1, 0);
        for (int i = 0; i < 24 && mq.size() != 0; i++)
            step(1, 0, '0, (i % 3) == 0, 0);
        drain(20);
        check("bp_len", sent.size(), 6);
        for (int i = 0; i < 6 && i < sent.size(); i++)
            check($sformatf("bp_b%0d", i), sent[i], exp_b[i]);

        // three results into a two-deep FIFO
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, C_EX, 0, 0);
        check("ovf_set", overflow, 1);
        drain(30);
        check("ovf_len", sent.size(), 12);
        if (sent.size() == 12) begin
            check("ovf_h0", sent[0], 8'hA0);
            check("ovf_h1", sent[6], 8'hA1);
        end
        step(1, 0, '0, 1, 1);
        check("ovf_clr", overflow, 0);

        // push coinciding with the CSUM pop on a full FIFO
        do_reset();
        step(1, 1, C_EX, 0, 0);
        step(1, 1, 20'h12345, 0, 0);
        for (int i = 0; i < 20 && pos != 5; i++) step(1, 0, '0, 1, 0);
        step(1, 1, 20'hABCDE, 1, 0);
        check("fullpop_ovf", overflow, 0);
        drain(30);
        check("fullpop_len", sent.size(), 18);
        if (sent.size() == 18) check("fullpop_h2", sent[12], 8'hA2);

        // sequence wrap, then a pulse with ena low
        do_reset();
        for (int r = 0; r < 17; r++) begin
            step(1, 1, 20'($urandom), 1, 0);
            for (int i = 0; i < 6; i++) step(1, 0, '0, 1, 0);
        end
        check("wrap_len", sent.size(), 102);
        if (sent.size() == 102) begin
            check("wrap_h15", sent[90], 8'hAF);
            check("wrap_h16", sent[96], 8'hA0);
        end
        step(0, 1, C_EX, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);
        check("ena_off_len", sent.size(), 102);
        check("ena_off_busy", busy, 0);

        // asynchronous reset in the middle of a frame
        do_reset();
        step(1, 1, C_EX, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0);
        #2;
        do_reset();
        step(1, 1, 20'h0F0F0, 1, 0);
        drain(20);
        check("rst_mid_len", sent.size(), 6);
        if (sent.size() == 6) check("rst_mid_h", sent[0], 8'hA0);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                 20'($urandom), $urandom_range(0, 4) < 3,
                 $urandom_range(0, 19) == 0);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_result_streamer.md
# matmul_result_streamer

Downstream stage of the 2x2 signed matrix multiplier. Captures each completed result matrix C (four 5-bit signed elements) into a small frame FIFO and streams it out as 6-byte framed packets over an 8-bit valid/ready byte interface: header, four sign-extended elements, XOR checksum. It decouples the multiplier's one-shot result pulse from a slower byte consumer and flags results lost to back-pressure.

## Interface
Parameters:
- DEPTH, 2, frame FIFO depth in frames; power of two, ≥2

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; when 0, c_valid is ignored (not counted as overflow); output side keeps running
- c_in  in  20  result matrix: [19:15]=c00, [14:10]=c01, [9:5]=c10, [4:0]=c11, each two's complement
- c_valid  in  1  one-cycle qualifier for c_in
- out_data  out  8  current stream byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts byte
- overflow  out  1  sticky: a valid result was dropped because the FIFO was full
- clr_ovf  in  1  synchronous clear of overflow
- busy  out  1  FIFO non-empty or frame in progress

## Operation
- Capture: on an edge with ena && c_valid && FIFO not full, push {seq, c00..c11, checksum}; seq (4 bits) increments, wrapping 15→0.
- Frame bytes, in order: {4'hA, seq}, sext8(c00), sext8(c01), sext8(c10), sext8(c11), XOR of the preceding five bytes. Checksum computed at capture.
- Serializer FSM: IDLE → HDR → ELEM (idx 0..3) → CSUM → HDR if FIFO holds another frame, else IDLE. Advance only on out_valid && out_ready. FIFO pop occurs on the CSUM handshake.
- Full FIFO + c_valid: result discarded, seq not incremented, overflow set.
- Simultaneous CSUM pop and push on full FIFO: push accepted (slot freed same edge), no overflow.
- Simultaneous clr_ovf and new overflow event: overflow stays 1 (set wins).
- ena low mid-frame: frame in flight and queued frames still drain.

## Timing
- Reset values: out_data=0x00, out_valid=0, overflow=0, busy=0, seq=0, FIFO empty, FSM IDLE.
- Latency: result captured at edge E with FIFO empty → out_valid=1 with header byte in the cycle after E (1 cycle).
- Throughput: one byte per cycle with out_ready held high; back-to-back frames with no idle cycle between CSUM and next HDR.
- Stream rule: while out_valid && !out_ready, out_data and out_valid hold stable.
- out_valid never drops mid-frame; deasserts only after the last CSUM handshake with FIFO empty.
- Asynchronous reset mid-frame: all state cleared immediately; partial frame abandoned, no resumption.
- busy=1 from the edge after capture through the edge completing the final CSUM handshake.

## Structure
- Shared package matmul_pkg: ELEM_W=5, FRAME_BYTES=6, HDR_NIBBLE=4'hA, serializer state enum, result-matrix packed struct (c00..c11), sext-to-byte function.
- Sub-module result_fifo: synchronous frame FIFO (DEPTH × 44-bit entry: 4 seq + 32 sign-extended elements + 8 checksum), push/pop/full/empty, simultaneous push+pop when full permitted.
- Top holds capture logic, seq counter, overflow flag, serializer FSM, byte mux.

## Test plan
- Single frame: c00=3, c01=-1, c10=0, c11=8, out_ready=1 → bytes A0 03 FF 00 08 54 on six consecutive cycles, out_valid starts one cycle after capture, then out_valid=0, busy=0.
- Back-pressure: same frame, out_ready toggled 1,0,0,1,… → byte sequence unchanged, out_data stable during every stall cycle.
- Overflow: out_ready=0, three results pushed (DEPTH=2) → overflow=1, only two frames emitted (headers A0, A1) once out_ready=1; clr_ovf → overflow=0.
- Full + pop same edge: FIFO full, push coincident with CSUM handshake → accepted, overflow stays 0, third frame header A2 follows.
- Seq wrap and ena: 17 results with ena=1 → 17th header A0; c_valid pulse with ena=0 → no frame, overflow unchanged.
- Reset mid-frame: rst_n low after ELEM byte 1 → out_valid=0, out_data=00 immediately; next result emits header A0.
